// File: rtl/hilo_mdu_if.sv
// Execute-stage <-> MDU signal bundle: start/op/operands one way, Busy and HI/LO back.
interface hilo_mdu_if;
  logic        Start;
  logic [2:0]  MDUOp;
  logic [31:0] A;
  logic [31:0] B;
  logic        Busy;
  logic [31:0] HI;
  logic [31:0] LO;

  modport master (output Start, MDUOp, A, B, input  Busy, HI, LO);
  modport slave  (input  Start, MDUOp, A, B, output Busy, HI, LO);
endinterface

// File: rtl/hilo_mdu_core.sv
// Fixed-latency multiply/divide unit owning the architectural HI/LO registers.
// Optional: define MDU_MADD_EN to enable MDUOp 7 (signed multiply-accumulate into HI/LO).
module hilo_mdu_core #(
  parameter int unsigned MULT_CYCLES = 5,
  parameter int unsigned DIV_CYCLES  = 10
) (
  input  logic      clk,
  input  logic      reset,
  hilo_mdu_if.slave mdu
);
  localparam int unsigned MAXC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int          CW   = $clog2(MAXC + 1);

  localparam logic [2:0] OP_MULT  = 3'd1;
  localparam logic [2:0] OP_MULTU = 3'd2;
  localparam logic [2:0] OP_DIV   = 3'd3;
  localparam logic [2:0] OP_DIVU  = 3'd4;
  localparam logic [2:0] OP_MTHI  = 3'd5;
  localparam logic [2:0] OP_MTLO  = 3'd6;
`ifdef MDU_MADD_EN
  localparam logic [2:0] OP_MADD  = 3'd7;
`endif

  typedef enum logic {S_IDLE, S_RUN} state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [31:0]     phi_q, plo_q;
  logic            pwr_q;
  logic [31:0]     hi_q, lo_q;

  logic            commit;
  logic            is_calc;
  logic            res_wr;
  logic [63:0]     res;
  logic [CW-1:0]   run_len;

  // One 64-bit multiplier serves both signednesses: the low 64 bits of the
  // product are correct once the operands are sign- or zero-extended.
  logic            mul_sgn;
  logic [63:0]     ma, mb, prod;

  always_comb begin
    mul_sgn = (mdu.MDUOp != OP_MULTU);
    ma      = {{32{mul_sgn & mdu.A[31]}}, mdu.A};
    mb      = {{32{mul_sgn & mdu.B[31]}}, mdu.B};
    prod    = ma * mb;
  end

  // Signed divide runs on magnitudes so that 0x80000000 / -1 and the
  // truncate-toward-zero rules fall out without special cases.
  logic        div_sgn, a_neg, b_neg, b_nz;
  logic [31:0] a_mag, b_mag, b_den, uq, ur, q_s, r_s;

  always_comb begin
    div_sgn = (mdu.MDUOp == OP_DIV);
    a_neg   = div_sgn & mdu.A[31];
    b_neg   = div_sgn & mdu.B[31];
    a_mag   = a_neg ? -mdu.A : mdu.A;
    b_mag   = b_neg ? -mdu.B : mdu.B;
    b_nz    = (mdu.B != 32'd0);
    b_den   = b_nz ? b_mag : 32'd1;
    uq      = a_mag / b_den;
    ur      = a_mag % b_den;
    q_s     = (a_neg ^ b_neg) ? -uq : uq;
    r_s     = a_neg ? -ur : ur;
  end

  always_comb begin
    res     = '0;
    res_wr  = 1'b0;
    is_calc = 1'b0;
    run_len = CW'(MULT_CYCLES);
    case (mdu.MDUOp)
      OP_MULT, OP_MULTU: begin
        res     = prod;
        res_wr  = 1'b1;
        is_calc = 1'b1;
      end
      OP_DIV, OP_DIVU: begin
        res     = {r_s, q_s};
        res_wr  = b_nz;
        is_calc = 1'b1;
        run_len = CW'(DIV_CYCLES);
      end
`ifdef MDU_MADD_EN
      OP_MADD: begin
        res     = {hi_q, lo_q} + prod;
        res_wr  = 1'b1;
        is_calc = 1'b1;
      end
`endif
      default: ;
    endcase
  end

  // FSM: state register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // FSM: next state
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    commit  = 1'b0;
    case (state_q)
      S_IDLE: if (mdu.Start && is_calc) begin
        state_d = S_RUN;
        cnt_d   = run_len;
      end
      S_RUN: begin
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          commit  = 1'b1;
          state_d = S_IDLE;
          cnt_d   = '0;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // FSM: outputs
  always_comb begin
    mdu.Busy = (state_q == S_RUN);
    mdu.HI   = hi_q;
    mdu.LO   = lo_q;
  end

  // Pending result and architectural HI/LO; Start is only honoured in IDLE.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      phi_q <= '0;
      plo_q <= '0;
      pwr_q <= 1'b0;
      hi_q  <= '0;
      lo_q  <= '0;
    end else begin
      if (state_q == S_IDLE && mdu.Start) begin
        if (is_calc) begin
          {phi_q, plo_q} <= res;
          pwr_q          <= res_wr;
        end
        if (mdu.MDUOp == OP_MTHI) hi_q <= mdu.A;
        if (mdu.MDUOp == OP_MTLO) lo_q <= mdu.A;
      end
      if (commit && pwr_q) begin
        hi_q <= phi_q;
        lo_q <= plo_q;
      end
    end
  end
endmodule

// File: tb/tb_hilo_mdu_core.sv
// Directed bench for hilo_mdu_core: reset, mult/div, div-by-zero, abort, mthi/mtlo, madd.
module tb_hilo_mdu_core;
  logic clk = 1'b0;
  logic reset;
  int   total = 0;
  int   bad   = 0;

  hilo_mdu_if mif();

  hilo_mdu_core #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk   (clk),
    .reset (reset),
    .mdu   (mif)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    mif.Start = 1'b1; mif.MDUOp = op; mif.A = a; mif.B = b;
    @(negedge clk);
    mif.Start = 1'b0; mif.MDUOp = 3'd0;
  endtask

  // Counts remaining Busy cycles, sampling at negedges; bounded.
  task automatic wait_idle(output int n);
    n = 0;
    while (mif.Busy === 1'b1 && n < 200) begin
      n++;
      @(negedge clk);
    end
  endtask

  task automatic run_op(input string tag, input logic [2:0] op, input logic [31:0] a,
                        input logic [31:0] b, input int ncyc,
                        input logic [31:0] ehi, input logic [31:0] elo);
    int n;
    issue(op, a, b);
    wait_idle(n);
    chk({tag, ".cycles"}, 32'(n), 32'(ncyc));
    chk({tag, ".hi"}, mif.HI, ehi);
    chk({tag, ".lo"}, mif.LO, elo);
  endtask

  initial begin
    int n;
    // Start presented while reset is held must be ignored
    reset = 1'b0;
    mif.Start = 1'b1; mif.MDUOp = 3'd1; mif.A = 32'd3; mif.B = 32'd5;
    repeat (3) @(negedge clk);
    reset = 1'b1; mif.Start = 1'b0; mif.MDUOp = 3'd0;
    chk("rst.busy", {31'd0, mif.Busy}, 32'd0);
    chk("rst.hi", mif.HI, 32'd0);
    chk("rst.lo", mif.LO, 32'd0);
    @(negedge clk);
    chk("rst.busy2", {31'd0, mif.Busy}, 32'd0);

    run_op("mult",  3'd1, 32'hFFFFFFFE, 32'd3, 5, 32'hFFFFFFFF, 32'hFFFFFFFA);
    run_op("multu", 3'd2, 32'hFFFFFFFE, 32'd3, 5, 32'h00000002, 32'hFFFFFFFA);
    run_op("div",   3'd3, 32'hFFFFFFF9, 32'd2, 10, 32'hFFFFFFFF, 32'hFFFFFFFD);
    run_op("divu",  3'd4, 32'd7, 32'd2, 10, 32'd1, 32'd3);
    run_op("divovf", 3'd3, 32'h80000000, 32'hFFFFFFFF, 10, 32'd0, 32'h80000000);

    // Preload then divide by zero: HI/LO must survive the commit
    issue(3'd5, 32'h11, 32'd0);
    chk("mthi.busy", {31'd0, mif.Busy}, 32'd0);
    issue(3'd6, 32'h22, 32'd0);
    chk("mtlo.hi", mif.HI, 32'h11);
    chk("mtlo.lo", mif.LO, 32'h22);
    run_op("div0", 3'd3, 32'd9, 32'd0, 10, 32'h11, 32'h22);

    // Abort a divide in its fourth Busy cycle
    issue(3'd3, 32'd100, 32'd7);
    repeat (3) @(negedge clk);
    reset = 1'b0;
    #1;
    chk("abort.busy", {31'd0, mif.Busy}, 32'd0);
    chk("abort.hi", mif.HI, 32'd0);
    chk("abort.lo", mif.LO, 32'd0);
    @(negedge clk);
    reset = 1'b1;
    repeat (12) @(negedge clk);
    chk("abort.busy_late", {31'd0, mif.Busy}, 32'd0);
    chk("abort.hi_late", mif.HI, 32'd0);
    chk("abort.lo_late", mif.LO, 32'd0);

    issue(3'd5, 32'hDEADBEEF, 32'd0);
    chk("mthi.hi", mif.HI, 32'hDEADBEEF);
    chk("mthi.busy2", {31'd0, mif.Busy}, 32'd0);

    // mtlo pulsed during a mult run is dropped
    issue(3'd1, 32'h00010000, 32'h00010000);
    mif.Start = 1'b1; mif.MDUOp = 3'd6; mif.A = 32'h1234;
    @(negedge clk);
    mif.Start = 1'b0; mif.MDUOp = 3'd0;
    chk("ign.lo_mid", mif.LO, 32'd0);
    wait_idle(n);
    chk("ign.cycles", 32'(n + 1), 32'd5);
    chk("ign.hi", mif.HI, 32'd1);
    chk("ign.lo", mif.LO, 32'd0);

    // madd from HI=0, LO=0xFFFFFFFF with 1*1
    issue(3'd5, 32'd0, 32'd0);
    issue(3'd6, 32'hFFFFFFFF, 32'd0);
`ifdef MDU_MADD_EN
    run_op("madd", 3'd7, 32'd1, 32'd1, 5, 32'd1, 32'd0);
`else
    issue(3'd7, 32'd1, 32'd1);
    chk("madd_off.busy", {31'd0, mif.Busy}, 32'd0);
    repeat (6) @(negedge clk);
    chk("madd_off.hi", mif.HI, 32'd0);
    chk("madd_off.lo", mif.LO, 32'hFFFFFFFF);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
